// File: rtl/monitor_baterias_multicanal_pkg.sv
// Shared definitions for the multichannel battery monitor: state encoding,
// default thresholds and the counter-width helper.
package monitor_baterias_multicanal_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    BAJANDO  = 2'd1,
    BAJA     = 2'd2,
    SUBIENDO = 2'd3
  } estado_t;

  localparam int unsigned NUM_BATERIAS_DEF  = 2;
  localparam int unsigned ANCHO_CARGA_DEF   = 4;
  localparam int unsigned UMBRAL_BAJO_DEF   = 3;
  localparam int unsigned UMBRAL_RECUP_DEF  = 5;
  localparam int unsigned CICLOS_FILTRO_DEF = 4;

  // Bits needed to hold values 0..valor-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned valor);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (valor > 0) ? valor - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/monitor_baterias_canal.sv
// Single battery channel: filtered low/recovered band FSM with hysteresis,
// discharged flag and sticky alarm cleared by acknowledge.
module canal_bateria
  import monitor_baterias_multicanal_pkg::*;
#(
  parameter int unsigned ANCHO_CARGA   = ANCHO_CARGA_DEF,
  parameter int unsigned UMBRAL_BAJO   = UMBRAL_BAJO_DEF,
  parameter int unsigned UMBRAL_RECUP  = UMBRAL_RECUP_DEF,
  parameter int unsigned CICLOS_FILTRO = CICLOS_FILTRO_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ANCHO_CARGA-1:0] carga,
  input  logic                   muestra_valida,
  input  logic                   reconocer,
  output logic                   advertencia_baja,
  output logic                   advertencia_descargada,
  output logic                   alarma_pendiente
);

  localparam int unsigned ANCHO_CNT = clog2(CICLOS_FILTRO + 1);
  localparam logic [ANCHO_CNT-1:0]   FILTRO_N = ANCHO_CNT'(CICLOS_FILTRO);
  localparam logic [ANCHO_CNT-1:0]   UNO_N    = ANCHO_CNT'(1);
  localparam logic [ANCHO_CARGA-1:0] BAJO_N   = ANCHO_CARGA'(UMBRAL_BAJO);
  localparam logic [ANCHO_CARGA-1:0] RECUP_N  = ANCHO_CARGA'(UMBRAL_RECUP);

  estado_t              estado, estado_sig;
  logic [ANCHO_CNT-1:0] cnt, cnt_sig, cnt_inc;
  logic                 es_bajo, es_recup, banda_baja_sig, entra_baja;

  assign es_bajo  = (carga <= BAJO_N);
  assign es_recup = (carga >= RECUP_N);
  assign cnt_inc  = (cnt == FILTRO_N) ? cnt : cnt + UNO_N;

  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    if (muestra_valida) begin
      unique case (estado)
        NORMAL: begin
          if (es_bajo) begin
            cnt_sig    = UNO_N;
            estado_sig = (CICLOS_FILTRO == 1) ? BAJA : BAJANDO;
          end else begin
            cnt_sig = '0;
          end
        end
        BAJANDO: begin
          if (es_bajo) begin
            if (cnt_inc == FILTRO_N) begin
              estado_sig = BAJA;
              cnt_sig    = '0;
            end else begin
              cnt_sig = cnt_inc;
            end
          end else begin
            estado_sig = NORMAL;
            cnt_sig    = '0;
          end
        end
        BAJA: begin
          if (es_recup) begin
            cnt_sig    = UNO_N;
            estado_sig = (CICLOS_FILTRO == 1) ? NORMAL : SUBIENDO;
          end
        end
        SUBIENDO: begin
          if (es_recup) begin
            if (cnt_inc == FILTRO_N) begin
              estado_sig = NORMAL;
              cnt_sig    = '0;
            end else begin
              cnt_sig = cnt_inc;
            end
          end else begin
            estado_sig = BAJA;
            cnt_sig    = '0;
          end
        end
        default: begin
          estado_sig = NORMAL;
          cnt_sig    = '0;
        end
      endcase
    end
  end

  assign banda_baja_sig = (estado_sig == BAJA) || (estado_sig == SUBIENDO);
  // Only a fresh entry raises the alarm; falling back from SUBIENDO does not.
  assign entra_baja = muestra_valida && (estado_sig == BAJA) &&
                      ((estado == NORMAL) || (estado == BAJANDO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado                 <= NORMAL;
      cnt                    <= '0;
      advertencia_descargada <= 1'b0;
      alarma_pendiente       <= 1'b0;
    end else begin
      estado <= estado_sig;
      cnt    <= cnt_sig;
      if (muestra_valida)
        advertencia_descargada <= (carga == '0) && banda_baja_sig;
      if (entra_baja)
        alarma_pendiente <= 1'b1;
      else if (reconocer)
        alarma_pendiente <= 1'b0;
    end
  end

  assign advertencia_baja = (estado == BAJA) || (estado == SUBIENDO);

endmodule

// File: rtl/monitor_baterias_multicanal.sv
// Multichannel battery monitor: one canal_bateria per packed reading plus a
// global OR of the sticky alarms.
module monitor_baterias_multicanal
  import monitor_baterias_multicanal_pkg::*;
#(
  parameter int unsigned NUM_BATERIAS  = NUM_BATERIAS_DEF,
  parameter int unsigned ANCHO_CARGA   = ANCHO_CARGA_DEF,
  parameter int unsigned UMBRAL_BAJO   = UMBRAL_BAJO_DEF,
  parameter int unsigned UMBRAL_RECUP  = UMBRAL_RECUP_DEF,
  parameter int unsigned CICLOS_FILTRO = CICLOS_FILTRO_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BATERIAS*ANCHO_CARGA-1:0] carga_baterias,
  input  logic                              muestra_valida,
  input  logic [NUM_BATERIAS-1:0]           reconocer,
  output logic [NUM_BATERIAS-1:0]           advertencia_baja,
  output logic [NUM_BATERIAS-1:0]           advertencia_descargada,
  output logic [NUM_BATERIAS-1:0]           alarma_pendiente,
  output logic                              alarma_global
);

  for (genvar i = 0; i < NUM_BATERIAS; i++) begin : g_canal
    canal_bateria #(
      .ANCHO_CARGA   (ANCHO_CARGA),
      .UMBRAL_BAJO   (UMBRAL_BAJO),
      .UMBRAL_RECUP  (UMBRAL_RECUP),
      .CICLOS_FILTRO (CICLOS_FILTRO)
    ) u_canal (
      .clk                    (clk),
      .rst                    (rst),
      .carga                  (carga_baterias[i*ANCHO_CARGA +: ANCHO_CARGA]),
      .muestra_valida         (muestra_valida),
      .reconocer              (reconocer[i]),
      .advertencia_baja       (advertencia_baja[i]),
      .advertencia_descargada (advertencia_descargada[i]),
      .alarma_pendiente       (alarma_pendiente[i])
    );
  end

  // OR of flop outputs: same timing as alarma_pendiente itself.
  assign alarma_global = |alarma_pendiente;

endmodule

// File: tb/tb_monitor_baterias_multicanal.sv
// Bench for monitor_baterias_multicanal: directed vector table, reset corner
// case, then randomized traffic against a band/streak reference model.
module tb_monitor_baterias_multicanal;

  localparam int NB = 2;
  localparam int AC = 4;
  localparam int UB = 3;
  localparam int UR = 5;
  localparam int CF = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB*AC-1:0]  carga;
  logic              valid;
  logic [NB-1:0]     ack;
  logic [NB-1:0]     baja, desc, alarma;
  logic              glob;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  monitor_baterias_multicanal #(
    .NUM_BATERIAS  (NB),
    .ANCHO_CARGA   (AC),
    .UMBRAL_BAJO   (UB),
    .UMBRAL_RECUP  (UR),
    .CICLOS_FILTRO (CF)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .carga_baterias         (carga),
    .muestra_valida         (valid),
    .reconocer              (ack),
    .advertencia_baja       (baja),
    .advertencia_descargada (desc),
    .alarma_pendiente       (alarma),
    .alarma_global          (glob)
  );

  // Reference model: band + streak of qualifying valid samples per channel.
  bit m_low   [NB];
  int m_streak[NB];
  bit m_desc  [NB];
  bit m_alarm [NB];

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_low[i] = 0; m_streak[i] = 0; m_desc[i] = 0; m_alarm[i] = 0;
    end
  endtask

  task automatic model_step(input logic [NB*AC-1:0] c, input logic v, input logic [NB-1:0] a);
    for (int i = 0; i < NB; i++) begin
      int r;
      bit q;
      bit entered;
      r = int'(c[i*AC +: AC]);
      entered = 0;
      if (v) begin
        q = m_low[i] ? (r >= UR) : (r <= UB);
        m_streak[i] = q ? m_streak[i] + 1 : 0;
        if (m_streak[i] >= CF) begin
          m_low[i] = !m_low[i];
          m_streak[i] = 0;
          entered = m_low[i];
        end
        m_desc[i] = (r == 0) && m_low[i];
      end
      if (entered) m_alarm[i] = 1;
      else if (a[i]) m_alarm[i] = 0;
    end
  endtask

  function automatic logic [NB-1:0] pack_bits(input bit b0, input bit b1);
    return {b1, b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NB*AC-1:0] c, input logic v, input logic [NB-1:0] a);
    carga = c; valid = v; ack = a;
    @(posedge clk);
    model_step(c, v, a);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [NB-1:0] eb, input logic [NB-1:0] ed,
                         input logic [NB-1:0] ea);
    chk({tag, ".baja"},   32'(baja),   32'(eb));
    chk({tag, ".desc"},   32'(desc),   32'(ed));
    chk({tag, ".alarma"}, 32'(alarma), 32'(ea));
    chk({tag, ".global"}, 32'(glob),   32'(|ea));
  endtask

  typedef struct {
    logic [NB*AC-1:0] carga;
    logic             valid;
    logic [NB-1:0]    ack;
    logic [NB-1:0]    baja;
    logic [NB-1:0]    desc;
    logic [NB-1:0]    alarma;
  } vec_t;

  vec_t tabla[$];

  task automatic add(input logic [NB*AC-1:0] c, input logic v, input logic [NB-1:0] a,
                     input logic [NB-1:0] eb, input logic [NB-1:0] ed, input logic [NB-1:0] ea);
    vec_t t;
    t.carga = c; t.valid = v; t.ack = a; t.baja = eb; t.desc = ed; t.alarma = ea;
    tabla.push_back(t);
  endtask

  initial begin
    int mode[NB];

    // Filter: 2,2,2, neutral 4, then 2 x4 (channel 1 reads 15 throughout)
    repeat (3) add(8'hF2, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(8'hF4, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (3) add(8'hF2, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(8'hF2, 1, 2'b00, 2'b01, 2'b00, 2'b01);
    // Hysteresis: neutral band keeps BAJA; ack on the last one
    repeat (9) add(8'hF4, 1, 2'b00, 2'b01, 2'b00, 2'b01);
    add(8'hF4, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    // 6,6 then 3 falls back to BAJA without re-arming the alarm
    repeat (2) add(8'hF6, 1, 2'b00, 2'b01, 2'b00, 2'b00);
    add(8'hF3, 1, 2'b00, 2'b01, 2'b00, 2'b00);
    repeat (3) add(8'hF6, 1, 2'b00, 2'b01, 2'b00, 2'b00);
    add(8'hF6, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // Ack with alarm already clear
    add(8'hF6, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    // Invalid samples with low readings change nothing
    repeat (20) add(8'hF2, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    // Ack held in the exact entry cycle: set wins
    repeat (3) add(8'hF2, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(8'hF2, 1, 2'b01, 2'b01, 2'b00, 2'b01);
    // Channel 1 discharged, then reading 1
    repeat (3) add(8'h02, 1, 2'b00, 2'b01, 2'b00, 2'b01);
    add(8'h02, 1, 2'b00, 2'b11, 2'b10, 2'b11);
    add(8'h12, 1, 2'b00, 2'b11, 2'b00, 2'b11);
    add(8'h12, 0, 2'b10, 2'b11, 2'b00, 2'b01);

    carga = '0; valid = 0; ack = '0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("reset", 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < tabla.size(); k++) begin
      step(tabla[k].carga, tabla[k].valid, tabla[k].ack);
      chk_all($sformatf("vec%0d", k), tabla[k].baja, tabla[k].desc, tabla[k].alarma);
    end

    // Asynchronous reset mid-cycle with channel 0 in BAJA discards everything
    step(8'hF2, 1, 2'b00);
    chk("pre_rst.baja0", 32'(baja[0]), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst", 2'b00, 2'b00, 2'b00);
    #1 rst = 1'b0;
    repeat (3) begin
      step(8'hF2, 1, 2'b00);
      chk_all("post_rst_filter", 2'b00, 2'b00, 2'b00);
    end
    step(8'hF2, 1, 2'b00);
    chk_all("post_rst_entry", 2'b01, 2'b00, 2'b01);

    // Randomized traffic vs model
    for (int i = 0; i < NB; i++) mode[i] = 2;
    for (int n = 0; n < 3000; n++) begin
      logic [NB*AC-1:0] c;
      logic             v;
      logic [NB-1:0]    a;
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 11) == 0) mode[i] = int'($urandom_range(0, 2));
        case (mode[i])
          0:       c[i*AC +: AC] = AC'($urandom_range(0, UB));
          1:       c[i*AC +: AC] = AC'($urandom_range(UR, 15));
          default: c[i*AC +: AC] = AC'($urandom_range(0, 15));
        endcase
        a[i] = ($urandom_range(0, 7) == 0);
      end
      v = ($urandom_range(0, 3) != 0);
      step(c, v, a);
      chk_all("rand", pack_bits(m_low[0], m_low[1]), pack_bits(m_desc[0], m_desc[1]),
              pack_bits(m_alarm[0], m_alarm[1]));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk_all("rand_rst", 2'b00, 2'b00, 2'b00);
        #1 rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
